// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type codes, scheduler states and subpacket count for the
// hdmi data-island packet scheduler.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL            = 8'h00;
  localparam logic [7:0] PKT_ACR             = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE    = 8'h02;
  localparam logic [7:0] PKT_AUDIO_INFOFRAME = 8'h84;

  localparam int unsigned SUBPACKETS = 4;

  typedef enum logic [1:0] {
    ACR_PENDING,
    INFO_PENDING,
    STREAM
  } sched_state_t;

  // Number of samples one audio sample packet can take from a FIFO holding `level`.
  function automatic logic [2:0] pop_count_for(input int unsigned level);
    if (level >= SUBPACKETS) begin
      return 3'(SUBPACKETS);
    end
    return 3'(level);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock sample FIFO with a 4-entry head window and a 0..4 pop per cycle.
// Pushes are accepted against the pre-pop level, so a same-cycle pop never frees room.
module audio_sample_fifo
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 16,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            data,
  input  logic [2:0]                   pop_count,
  output logic [SUBPACKETS*DATA_W-1:0] head,
  output logic [LEVEL_W-1:0]           level
);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   rd_q;
  logic [PTR_W-1:0]   wr_q;
  logic [LEVEL_W-1:0] level_q;
  logic               accept;

  assign accept = push && (level_q < LEVEL_W'(DEPTH));
  assign level  = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      if (accept) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      rd_q    <= rd_q + PTR_W'(pop_count);
      level_q <= level_q + LEVEL_W'(accept) - LEVEL_W'(pop_count);
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_q] <= data;
    end
  end

  always_comb begin
    head = '0;
    for (int k = 0; k < int'(SUBPACKETS); k++) begin
      head[k*DATA_W +: DATA_W] = mem[rd_q + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/audio_packet_scheduler.sv
// Chooses the next hdmi data-island packet on each packet_enable: ACR, then
// Audio InfoFrame, then audio sample packets (up to 4 samples) or null packets.
module audio_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH      = 16,
  localparam int unsigned LEVEL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                  clk_pixel,
  input  logic                                  reset,
  input  logic                                  frame_start,
  input  logic                                  sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0]            sample_left,
  input  logic [AUDIO_BIT_WIDTH-1:0]            sample_right,
  input  logic                                  packet_enable,
  output logic [7:0]                            packet_type,
  output logic [SUBPACKETS*2*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic [SUBPACKETS-1:0]                 sample_present,
  output logic [LEVEL_W-1:0]                    fifo_level,
  output logic                                  overflow
);

  localparam int unsigned SAMPLE_W = 2 * AUDIO_BIT_WIDTH;
  localparam int unsigned WORD_W   = SUBPACKETS * SAMPLE_W;

  sched_state_t          state_q, state_d, cur_state;
  logic [7:0]            type_q, type_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [SUBPACKETS-1:0] present_q, present_d;
  logic                  overflow_q, overflow_d;
  logic [2:0]            pop_count;
  logic [2:0]            avail;
  logic [WORD_W-1:0]     head;
  logic [LEVEL_W-1:0]    level;

  audio_sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_pixel),
    .reset     (reset),
    .push      (sample_valid),
    .data      ({sample_right, sample_left}),
    .pop_count (pop_count),
    .head      (head),
    .level     (level)
  );

  assign avail = pop_count_for(32'(level));

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    word_d     = word_q;
    present_d  = present_q;
    pop_count  = '0;
    overflow_d = overflow_q | (sample_valid && (level == LEVEL_W'(FIFO_DEPTH)));
    // A frame start outranks whatever state the scheduler was in, even this cycle.
    cur_state  = frame_start ? ACR_PENDING : state_q;
    state_d    = cur_state;

    if (packet_enable) begin
      word_d    = '0;
      present_d = '0;
      case (cur_state)
        ACR_PENDING: begin
          type_d  = PKT_ACR;
          state_d = INFO_PENDING;
        end
        INFO_PENDING: begin
          type_d  = PKT_AUDIO_INFOFRAME;
          state_d = STREAM;
        end
        STREAM: begin
          state_d = STREAM;
          if (avail != '0) begin
            type_d    = PKT_AUDIO_SAMPLE;
            pop_count = avail;
            for (int k = 0; k < int'(SUBPACKETS); k++) begin
              if (3'(k) < avail) begin
                word_d[k*SAMPLE_W +: SAMPLE_W] = head[k*SAMPLE_W +: SAMPLE_W];
                present_d[k]                   = 1'b1;
              end
            end
          end else begin
            type_d = PKT_NULL;
          end
        end
        default: begin
          type_d  = PKT_NULL;
          state_d = ACR_PENDING;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q    <= ACR_PENDING;
      type_q     <= PKT_NULL;
      word_q     <= '0;
      present_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      word_q     <= word_d;
      present_q  <= present_d;
      overflow_q <= overflow_d;
    end
  end

  assign packet_type       = type_q;
  assign audio_sample_word = word_q;
  assign sample_present    = present_q;
  assign fifo_level        = level;
  assign overflow          = overflow_q;

endmodule

// File: doc/audio_packet_scheduler.md
Name: audio_packet_scheduler

Overview:
Single-clock packet scheduler feeding the hdmi core's packet interface in the clk_pixel domain. It buffers stereo audio samples arriving as strobes, and on each packet_enable it picks the next data-island packet type. Per frame it sends Audio Clock Regeneration first, then the Audio InfoFrame, then audio sample packets of up to 4 samples, and null packets when nothing is pending. It replaces the ad-hoc per-top packet selection logic.

Parameters:
AUDIO_BIT_WIDTH, 16, bits per channel sample
FIFO_DEPTH, 16, sample FIFO entries (stereo pairs); power of 2, minimum 4
LEVEL_W, $clog2(FIFO_DEPTH)+1, derived width of fifo_level (localparam)

Ports:
clk_pixel  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse at cx==0 && cy==0
sample_valid  input  1  one-cycle strobe: sample_left/right valid (already synchronised to clk_pixel)
sample_left  input  AUDIO_BIT_WIDTH  left channel sample
sample_right  input  AUDIO_BIT_WIDTH  right channel sample
packet_enable  input  1  one-cycle pulse from hdmi: choose next packet
packet_type  output  8  packet type presented to hdmi
audio_sample_word  output  4*2*AUDIO_BIT_WIDTH  subpacket k at [k*2W +: 2W], {right,left}
sample_present  output  4  bit k set = subpacket k carries a valid sample
fifo_level  output  LEVEL_W  current FIFO occupancy
overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset: packet_type=0x00, audio_sample_word=0, sample_present=0, fifo_level=0, overflow=0, FSM=ACR_PENDING, FIFO pointers cleared. Reset mid-operation discards buffered samples.
- FIFO write: on sample_valid when level<FIFO_DEPTH, push {right,left}. When full, drop the sample and set overflow. overflow clears only on reset.
- FSM states: ACR_PENDING -> INFO_PENDING -> STREAM.
  - frame_start forces ACR_PENDING from any state.
  - Transitions occur only on packet_enable.
- Selection on packet_enable in cycle t; outputs registered and valid in cycle t+1 (latency 1). Outputs hold until the next packet_enable.
  - ACR_PENDING: packet_type=0x01, sample_present=0, go to INFO_PENDING.
  - INFO_PENDING: packet_type=0x84, sample_present=0, go to STREAM.
  - STREAM with level>0:
    - packet_type=0x02.
    - Pop n=min(level,4) entries in FIFO order into subpackets 0..n-1.
    - sample_present = low n bits set.
    - Unused subpackets are zero.
  - STREAM with level==0: packet_type=0x00, sample_present=0, audio_sample_word=0.
- frame_start and packet_enable in the same cycle: the frame reset takes priority, so the packet is ACR (0x01) and the next state is INFO_PENDING.
- Simultaneous push and pop: the pop count uses the pre-write level. New level = level + push − n. A push is accepted if level<FIFO_DEPTH before the pop, so it is never dropped because of the same-cycle pop.
- Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH and never underflows.
- Without packet_enable, no pops occur and no packet outputs change.

Decomposition:
- Package hdmi_packet_pkg:
  - PKT_NULL=8'h00, PKT_ACR=8'h01, PKT_AUDIO_SAMPLE=8'h02, PKT_AUDIO_INFOFRAME=8'h84
  - enum sched_state_t {ACR_PENDING, INFO_PENDING, STREAM}
  - constant SUBPACKETS=4
- Sub-module: audio_sample_fifo (single clock, synchronous reset).
  - Inputs: push, data, pop_count 0..4.
  - Outputs: head window of 4 entries, level.
- The scheduler holds the FSM and the output registers.

Test Plan:
- Reset, then frame_start, then 4 packet_enables with an empty FIFO -> packet_type sequence 0x01, 0x84, 0x00, 0x00; sample_present=0 throughout.
- After ACR/InfoFrame, push 6 samples (L=1..6, R=101..106) then pulse packet_enable twice:
  - 1st -> 0x02, present=4'b1111, subpackets {101,1}..{104,4};
  - 2nd -> 0x02, present=4'b0011, subpackets {105,5},{106,6}, rest 0; level ends at 0.
- Push 20 samples without packet_enable (DEPTH 16) -> fifo_level=16, overflow=1. Then drain -> first popped sample is the 1st written and the last is the 16th.
- sample_valid coincident with a packet_enable that pops 4 from level=4 -> output carries the old 4 samples, fifo_level=1 next cycle, new sample present in the next packet.
- frame_start in the same cycle as packet_enable while in STREAM -> packet_type=0x01, then 0x84 on the next packet_enable, and buffered samples are retained.
- Assert reset while level=7 and packet_type=0x02 -> next cycle all outputs zero, level=0, overflow=0; the next packet_enable yields 0x01.
